data_port_arbiter: RTL

Two-master arbiter that shares the memory controller's single data port between the CPU load/store unit (master 0) and a DMA/debug loader (master 1). It grants at most one request per cycle and drives the shared port. It tracks the port's one-cycle read latency so each read result returns only to the master that issued it. It sits between the core/DMA and the memory controller's data-side inputs.

---
 rtl/mem_pkg.sv | 18 +
 rtl/starve_counter.sv | 39 +++
 rtl/data_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory data-port arbiter: access widths, read owner,
// and arbiter FSM states.
package mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd1;
    localparam logic [1:0] WIDTH_HALF = 2'd2;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear and hold; hold has priority.
module starve_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LimitW = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!hold) begin
            if (clr) begin
                count_d = '0;
            end else if (inc && (count_q != LimitW)) begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_port_arbiter.sv
// Two-master arbiter for the memory controller's single data port, with
// starvation relief for the DMA master, DMA locking, and read-return routing.
module data_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [1:0]  i_cpu_width,
    input  logic        i_cpu_we,
    input  logic        i_cpu_zeroextend,
    output logic        o_cpu_stall,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_rvalid,
    input  logic        i_dma_req,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    input  logic [1:0]  i_dma_width,
    input  logic        i_dma_we,
    input  logic        i_dma_zeroextend,
    input  logic        i_dma_lock,
    output logic        o_dma_stall,
    output logic [31:0] o_dma_rdata,
    output logic        o_dma_rvalid,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_width,
    output logic        o_mem_we,
    output logic        o_mem_read_en,
    output logic        o_mem_zeroextend,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic          gnt0, gnt1;
    logic [CntW-1:0] starve_cnt;
    logic          starved;
    logic          rd_pend_q, rd_pend_d;
    owner_t        owner_q, owner_d;

    assign starved = (starve_cnt == CntW'(STARVE_LIMIT));

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            ARB: begin
                gnt1 = i_dma_req & (~i_cpu_req | starved);
                gnt0 = i_cpu_req & ~gnt1;
                if (gnt1 && i_dma_lock) state_d = LOCKED;
            end
            LOCKED: begin
                // Exit cycle still grants master 1; ARB resumes next cycle.
                gnt1 = i_dma_req;
                if (!i_dma_lock) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign o_cpu_stall = i_cpu_req & ~gnt0;
    assign o_dma_stall = i_dma_req & ~gnt1;

    // Idle port drives zeros so read_en can never pop a peripheral FIFO.
    always_comb begin
        o_mem_addr       = '0;
        o_mem_wdata      = '0;
        o_mem_width      = '0;
        o_mem_we         = 1'b0;
        o_mem_read_en    = 1'b0;
        o_mem_zeroextend = 1'b0;
        if (gnt1) begin
            o_mem_addr       = i_dma_addr;
            o_mem_wdata      = i_dma_wdata;
            o_mem_width      = i_dma_width;
            o_mem_we         = i_dma_we;
            o_mem_read_en    = ~i_dma_we;
            o_mem_zeroextend = i_dma_zeroextend;
        end else if (gnt0) begin
            o_mem_addr       = i_cpu_addr;
            o_mem_wdata      = i_cpu_wdata;
            o_mem_width      = i_cpu_width;
            o_mem_we         = i_cpu_we;
            o_mem_read_en    = ~i_cpu_we;
            o_mem_zeroextend = i_cpu_zeroextend;
        end
    end

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CntW)
    ) u_starve_counter (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (gnt1 | ~i_dma_req),
        .inc   (i_dma_req & ~gnt1),
        .hold  (state_q == LOCKED),
        .count (starve_cnt)
    );

    always_comb begin
        rd_pend_d = o_mem_read_en;
        owner_d   = owner_q;
        if (o_mem_read_en) owner_d = gnt1 ? OWN_DMA : OWN_CPU;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ARB;
            rd_pend_q <= 1'b0;
            owner_q   <= OWN_CPU;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
        end
    end

    assign o_cpu_rvalid = rd_pend_q & (owner_q == OWN_CPU);
    assign o_dma_rvalid = rd_pend_q & (owner_q == OWN_DMA);
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : 32'h0;
    assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : 32'h0;

endmodule
